// File: rtl/sdr_bank_tracker.sv
// Passive SDRAM per-bank state tracker: decodes the command bus, times tRCD/tRP/tRFC/bursts, flags illegal commands.
// Optional SDR_BANK_TRACK_ROW_EN adds the bank_row output holding each bank's last activated row.
module sdr_bank_tracker #(
    parameter int TRCD      = 2,
    parameter int TRP       = 2,
    parameter int TRFC      = 7,
    parameter int BURST_LEN = 4
) (
    input  logic        sdram_clk,
    input  logic        sdram_reset,
    input  logic        sdr_cs_n,
    input  logic        sdr_ras_n,
    input  logic        sdr_cas_n,
    input  logic        sdr_we_n,
    input  logic [1:0]  sdr_ba,
    input  logic [12:0] sdr_addr,
    output logic [11:0] bank_st,
    output logic        viol,
    output logic [2:0]  viol_code,
    output logic [1:0]  viol_bank
`ifdef SDR_BANK_TRACK_ROW_EN
    ,
    output logic [51:0] bank_row
`endif
);
    localparam int CMAX_A = (TRCD > TRP) ? TRCD : TRP;
    localparam int CMAX   = (CMAX_A > BURST_LEN + TRP) ? CMAX_A : BURST_LEN + TRP;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int RW     = (TRFC > 1) ? $clog2(TRFC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000, ST_PRE = 3'b001, ST_ACT = 3'b010, ST_XFR = 3'b011, ST_DLP = 3'b100
    } bank_state_e;

    typedef enum logic [2:0] {
        OP_NOP, OP_ACT, OP_RW, OP_BST, OP_PRE, OP_REF, OP_LMR
    } op_e;

    bank_state_e    st_q [4];
    bank_state_e    st_d [4];
    logic [CW-1:0]  cnt_q [4];
    logic [CW-1:0]  cnt_d [4];
    logic [RW-1:0]  trfc_q, trfc_d;
    logic           viol_q, viol_d;
    logic [2:0]     code_q, code_d;
    logic [1:0]     vbank_q, vbank_d;
    logic [3:0]     cmd;
    op_e            op;
    logic           any_xfr, all_idle;
    bank_state_e    tgt_st;

`ifdef SDR_BANK_TRACK_ROW_EN
    logic [3:0][12:0] row_q, row_d;
    assign bank_row = row_q;
`endif

    always_comb begin
        cmd = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
        op  = OP_NOP;
        if (!$isunknown(cmd) && !cmd[3]) begin
            case (cmd[2:0])
                3'b011:         op = OP_ACT;
                3'b101, 3'b100: op = OP_RW;
                3'b110:         op = OP_BST;
                3'b010:         op = OP_PRE;
                3'b001:         op = OP_REF;
                3'b000:         op = OP_LMR;
                default:        op = OP_NOP;
            endcase
        end
    end

    always_comb begin
        // Timer expiry first; the command is then judged against the post-expiry state.
        any_xfr  = 1'b0;
        all_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end else begin
                case (st_q[i])
                    ST_XFR:         st_d[i] = ST_ACT;
                    ST_PRE, ST_DLP: st_d[i] = ST_IDLE;
                    default:        st_d[i] = st_q[i];
                endcase
            end
            if (st_d[i] == ST_XFR)  any_xfr  = 1'b1;
            if (st_d[i] != ST_IDLE) all_idle = 1'b0;
        end
        trfc_d = (trfc_q != '0) ? trfc_q - 1'b1 : trfc_q;
        tgt_st = st_d[sdr_ba];
        code_d = 3'd0;
`ifdef SDR_BANK_TRACK_ROW_EN
        row_d = row_q;
`endif

        if (op != OP_NOP && trfc_q != '0) begin
            code_d = 3'd5;
        end else begin
            case (op)
                OP_ACT: begin
                    if (tgt_st != ST_IDLE) begin
                        code_d = 3'd3;
                    end else begin
                        st_d[sdr_ba]  = ST_ACT;
                        cnt_d[sdr_ba] = CW'(TRCD - 1);
`ifdef SDR_BANK_TRACK_ROW_EN
                        row_d[sdr_ba] = sdr_addr;
`endif
                    end
                end
                OP_RW: begin
                    if (tgt_st == ST_ACT && cnt_q[sdr_ba] != '0) begin
                        code_d = 3'd1;
                    end else if (tgt_st == ST_ACT || tgt_st == ST_XFR) begin
                        for (int i = 0; i < 4; i++) begin
                            if (st_d[i] == ST_XFR) begin
                                st_d[i]  = ST_ACT;
                                cnt_d[i] = '0;
                            end
                        end
                        if (sdr_addr[10]) begin
                            st_d[sdr_ba]  = ST_DLP;
                            cnt_d[sdr_ba] = CW'(BURST_LEN + TRP - 1);
                        end else begin
                            st_d[sdr_ba]  = ST_XFR;
                            cnt_d[sdr_ba] = CW'(BURST_LEN - 1);
                        end
                    end else begin
                        code_d = 3'd2;
                    end
                end
                OP_PRE: begin
                    for (int i = 0; i < 4; i++) begin
                        if ((sdr_addr[10] || 2'(i) == sdr_ba) &&
                            (st_d[i] == ST_ACT || st_d[i] == ST_XFR)) begin
                            st_d[i]  = ST_PRE;
                            cnt_d[i] = CW'(TRP - 1);
                        end
                    end
                end
                OP_BST: begin
                    if (!any_xfr) begin
                        code_d = 3'd6;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (st_d[i] == ST_XFR) begin
                                st_d[i]  = ST_ACT;
                                cnt_d[i] = '0;
                            end
                        end
                    end
                end
                OP_REF, OP_LMR: begin
                    if (!all_idle)          code_d = 3'd4;
                    else if (op == OP_REF)  trfc_d = RW'(TRFC - 1);
                end
                default: ;
            endcase
        end
        viol_d  = (code_d != 3'd0);
        vbank_d = viol_d ? sdr_ba : 2'd0;
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
            trfc_q  <= '0;
            viol_q  <= 1'b0;
            code_q  <= 3'd0;
            vbank_q <= 2'd0;
`ifdef SDR_BANK_TRACK_ROW_EN
            row_q   <= '0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            trfc_q  <= trfc_d;
            viol_q  <= viol_d;
            code_q  <= code_d;
            vbank_q <= vbank_d;
`ifdef SDR_BANK_TRACK_ROW_EN
            row_q   <= row_d;
`endif
        end
    end

`ifndef SDR_BANK_TRACK_ROW_EN
    logic unused_addr;
    assign unused_addr = ^{sdr_addr[12:11], sdr_addr[9:0]};
`endif

    always_comb begin
        bank_st = '0;
        for (int i = 0; i < 4; i++) bank_st[3*i +: 3] = st_q[i];
    end

    assign viol      = viol_q;
    assign viol_code = code_q;
    assign viol_bank = vbank_q;

endmodule

// File: tb/tb_sdr_bank_tracker.sv
// Directed bench for sdr_bank_tracker; expected values are hand-derived from TRCD=2 TRP=2 TRFC=7 BURST_LEN=4.
module tb_sdr_bank_tracker;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_BST = 4'b0110, C_PRE = 4'b0010, C_REF = 4'b0001;
    localparam logic [12:0] A10 = 13'h0400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic [12:0] addr = 13'd0;
    logic [11:0] bank_st;
    logic        viol;
    logic [2:0]  viol_code;
    logic [1:0]  viol_bank;
`ifdef SDR_BANK_TRACK_ROW_EN
    logic [51:0] bank_row;
`endif
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sdr_bank_tracker dut (
        .sdram_clk(clk), .sdram_reset(rst),
        .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
        .sdr_ba(ba), .sdr_addr(addr),
        .bank_st(bank_st), .viol(viol), .viol_code(viol_code), .viol_bank(viol_bank)
`ifdef SDR_BANK_TRACK_ROW_EN
        , .bank_row(bank_row)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one command, step one edge, settle so outputs reflect it.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba   = b;
        addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(C_NOP, 2'd0, 13'd0);
    endtask

    task automatic chk_v(input string tag, input logic v, input logic [2:0] code, input logic [1:0] b);
        chk({tag, "_viol"}, 64'(viol), 64'(v));
        chk({tag, "_code"}, 64'(viol_code), 64'(code));
        chk({tag, "_bank"}, 64'(viol_bank), 64'(b));
    endtask

    initial begin
        #1;
        nop();
        nop();
        chk("rst_st", 64'(bank_st), 64'h000);
        chk_v("rst", 1'b0, 3'd0, 2'd0);
`ifdef SDR_BANK_TRACK_ROW_EN
        chk("rst_row", 64'(bank_row), 64'd0);
`endif
        rst = 1'b0;

        // ACTIVE -> tRCD -> READ burst of 4, then back to ACT
        issue(C_ACT, 2'd1, 13'd0);
        chk("act1", 64'(bank_st), 64'h010);
        nop();
        chk("act1_hold", 64'(bank_st), 64'h010);
        issue(C_RD, 2'd1, 13'd0);
        chk("rd1_xfr", 64'(bank_st), 64'h018);
        chk_v("rd1", 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            nop();
            chk("xfr_hold", 64'(bank_st), 64'h018);
        end
        nop();
        chk("xfr_end", 64'(bank_st), 64'h010);

        // READ too early -> code 1, one-cycle pulse
        issue(C_ACT, 2'd2, 13'd0);
        chk("act2", 64'(bank_st), 64'h090);
        issue(C_RD, 2'd2, 13'd0);
        chk_v("trcd", 1'b1, 3'd1, 2'd2);
        chk("trcd_st", 64'(bank_st), 64'h090);
        nop();
        chk("pulse_clr", 64'(viol), 64'd0);

        // precharge-all of banks 1,2
        issue(C_PRE, 2'd0, A10);
        chk("pre12", 64'(bank_st), 64'h048);
        nop();
        chk("pre12_hold", 64'(bank_st), 64'h048);
        nop();
        chk("pre12_idle", 64'(bank_st), 64'h000);

        // banks 0,3 active, precharge-all
        issue(C_ACT, 2'd0, 13'd0);
        issue(C_ACT, 2'd3, 13'h1ABC);
        chk("act03", 64'(bank_st), 64'h402);
`ifdef SDR_BANK_TRACK_ROW_EN
        chk("row3", 64'(bank_row[51:39]), 64'h1ABC);
`endif
        issue(C_PRE, 2'd1, A10);
        chk("pre03", 64'(bank_st), 64'h201);
        nop();
        chk("pre03_hold", 64'(bank_st), 64'h201);
        nop();
        chk("pre03_idle", 64'(bank_st), 64'h000);

        // WRITE with auto-precharge: DMA_LAST_PRE for 6 cycles
        issue(C_ACT, 2'd0, 13'd0);
        nop();
        issue(C_WR, 2'd0, A10);
        chk("dlp", 64'(bank_st), 64'h004);
        for (int i = 0; i < 5; i++) begin
            nop();
            chk("dlp_hold", 64'(bank_st), 64'h004);
        end
        nop();
        chk("dlp_idle", 64'(bank_st), 64'h000);

        // codes 2, 3, 4
        issue(C_RD, 2'd0, 13'd0);
        chk_v("rd_idle", 1'b1, 3'd2, 2'd0);
        issue(C_ACT, 2'd0, 13'd0);
        issue(C_ACT, 2'd0, 13'd0);
        chk_v("act_twice", 1'b1, 3'd3, 2'd0);
        issue(C_REF, 2'd2, 13'd0);
        chk_v("ref_busy", 1'b1, 3'd4, 2'd2);
        chk("ref_busy_st", 64'(bank_st), 64'h002);
        issue(C_PRE, 2'd0, 13'd0);
        chk("pre0", 64'(bank_st), 64'h001);
        nop();
        nop();
        chk("pre0_idle", 64'(bank_st), 64'h000);

        // tRFC window
        issue(C_REF, 2'd0, 13'd0);
        chk_v("ref", 1'b0, 3'd0, 2'd0);
        nop();
        nop();
        issue(C_ACT, 2'd1, 13'd0);
        chk_v("trfc", 1'b1, 3'd5, 2'd1);
        chk("trfc_st", 64'(bank_st), 64'h000);
        nop();
        nop();
        nop();
        issue(C_ACT, 2'd0, 13'd0);
        chk_v("trfc_ok", 1'b0, 3'd0, 2'd0);
        chk("trfc_ok_st", 64'(bank_st), 64'h002);

        // burst terminate
        nop();
        issue(C_RD, 2'd0, 13'd0);
        chk("bst_pre", 64'(bank_st), 64'h003);
        issue(C_BST, 2'd0, 13'd0);
        chk("bst", 64'(bank_st), 64'h002);
        chk_v("bst", 1'b0, 3'd0, 2'd0);
        issue(C_BST, 2'd1, 13'd0);
        chk_v("bst_none", 1'b1, 3'd6, 2'd1);

        // burst restart to another bank returns the old one to ACT
        issue(C_ACT, 2'd3, 13'd0);
        issue(C_RD, 2'd0, 13'd0);
        chk("rst_burst_a", 64'(bank_st), 64'h403);
        issue(C_WR, 2'd3, 13'd0);
        chk("rst_burst_b", 64'(bank_st), 64'h602);
        issue(C_PRE, 2'd0, 13'd0);
        chk("mix", 64'(bank_st), 64'h601);

        // reset mid-burst overrides a would-be violation
        rst = 1'b1;
        issue(C_RD, 2'd1, 13'd0);
        chk("midrst_st", 64'(bank_st), 64'h000);
        chk_v("midrst", 1'b0, 3'd0, 2'd0);
`ifdef SDR_BANK_TRACK_ROW_EN
        chk("midrst_row", 64'(bank_row), 64'd0);
`endif
        rst = 1'b0;
        nop();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
